// File: rtl/spi_master_cu.sv
// SPI mode-0 burst master: CS-framed command byte, address byte, then LEN data bytes.
// Optional feature macro SPI_MASTER_ABORT_EN adds ABORT to end a burst at the next byte boundary.
module spi_master_cu #(
  parameter int unsigned CLK_DIV = 4,
  parameter logic [7:0]  CMD_RD  = 8'h03,
  parameter logic [7:0]  CMD_WR  = 8'h02
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       RW,
  input  logic [7:0] ADDR,
  input  logic [7:0] LEN,
  input  logic [7:0] TX_DATA,
  output logic       TX_ACK,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       BUSY,
  output logic       DONE,
  output logic       SCLK,
  output logic       CS,
  output logic       MOSI,
`ifdef SPI_MASTER_ABORT_EN
  input  logic       ABORT,
`endif
  input  logic       MISO
);
  localparam int unsigned      DIV_W   = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SEND_CMD, SEND_ADDR, XFER, CS_HOLD} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d, cs_q, cs_d, mosi_q, mosi_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             tx_ack_q, tx_ack_d, rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d, tx_sh_q, tx_sh_d, tx_hold_q, tx_hold_d;
  logic [7:0]       addr_q, addr_d, bytes_q, bytes_d;
  logic [6:0]       rx_sh_q, rx_sh_d;
  logic [2:0]       bit_q, bit_d;
  logic             rw_q, rw_d;
  logic             wrap, stop;
  logic [7:0]       cmd, next_byte;

  assign wrap = (div_q == DIV_MAX);
  assign cmd  = RW ? CMD_RD : CMD_WR;

`ifdef SPI_MASTER_ABORT_EN
  logic abort_q, abort_d;
  assign stop = abort_q | ABORT;
`else
  assign stop = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    sclk_d     = sclk_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_ack_d   = 1'b0;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    tx_sh_d    = tx_sh_q;
    tx_hold_d  = tx_hold_q;
    addr_d     = addr_q;
    bytes_d    = bytes_q;
    rx_sh_d    = rx_sh_q;
    bit_d      = bit_q;
    rw_d       = rw_q;
    next_byte  = '0;
`ifdef SPI_MASTER_ABORT_EN
    abort_d    = abort_q | (busy_q & ABORT);
`endif
    if (state_q != IDLE) div_d = wrap ? '0 : div_q + 1'b1;

    case (state_q)
      IDLE: if (START) begin
        state_d = CS_SETUP;
        cs_d    = 1'b0;
        busy_d  = 1'b1;
        rw_d    = RW;
        addr_d  = ADDR;
        bytes_d = (LEN == 8'd0) ? 8'd1 : LEN;
        tx_sh_d = cmd;
        mosi_d  = cmd[7];
        bit_d   = '0;
        rx_sh_d = '0;
`ifdef SPI_MASTER_ABORT_EN
        abort_d = 1'b0;
`endif
      end
      CS_SETUP: if (wrap) begin
        state_d = SEND_CMD;
        mosi_d  = tx_sh_q[7];
      end
      SEND_CMD, SEND_ADDR, XFER: if (wrap) begin
        if (!sclk_q) begin
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[5:0], MISO};
          bit_d   = bit_q + 3'd1;
          if (state_q == XFER && bit_q == 3'd7) begin
            bytes_d = bytes_q - 8'd1;
            if (rw_q) begin
              rx_data_d  = {rx_sh_q, MISO};
              rx_valid_d = 1'b1;
            end
          end
        end else begin
          sclk_d = 1'b0;
          // bit_q wraps to 0 after the 8th rise, so a zero here marks a byte boundary
          if (bit_q != 3'd0) begin
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
            mosi_d  = tx_sh_q[6];
          end else if (stop || (state_q == XFER && bytes_q == 8'd0)) begin
            state_d = CS_HOLD;
            tx_sh_d = '0;
            mosi_d  = 1'b0;
          end else begin
            if (state_q == SEND_CMD) begin
              state_d   = SEND_ADDR;
              next_byte = addr_q;
              if (!rw_q) begin
                tx_ack_d  = 1'b1;
                tx_hold_d = TX_DATA;
              end
            end else if (state_q == SEND_ADDR) begin
              state_d   = XFER;
              next_byte = rw_q ? 8'h00 : tx_hold_q;
            end else begin
              next_byte = rw_q ? 8'h00 : TX_DATA;
              tx_ack_d  = !rw_q;
            end
            tx_sh_d = next_byte;
            mosi_d  = next_byte[7];
          end
        end
      end
      CS_HOLD: if (wrap) begin
        state_d = IDLE;
        cs_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      div_q      <= '0;
      sclk_q     <= 1'b0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_ack_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      tx_sh_q    <= '0;
      tx_hold_q  <= '0;
      addr_q     <= '0;
      bytes_q    <= '0;
      rx_sh_q    <= '0;
      bit_q      <= '0;
      rw_q       <= 1'b0;
`ifdef SPI_MASTER_ABORT_EN
      abort_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_ack_q   <= tx_ack_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      tx_sh_q    <= tx_sh_d;
      tx_hold_q  <= tx_hold_d;
      addr_q     <= addr_d;
      bytes_q    <= bytes_d;
      rx_sh_q    <= rx_sh_d;
      bit_q      <= bit_d;
      rw_q       <= rw_d;
`ifdef SPI_MASTER_ABORT_EN
      abort_q    <= abort_d;
`endif
    end
  end

  assign TX_ACK   = tx_ack_q;
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign SCLK     = sclk_q;
  assign CS       = cs_q;
  assign MOSI     = mosi_q;
endmodule
